cpu_fetch_unit: RTL and testbench

Instruction fetch stage of the 8-bit-address / 12-bit-instruction CPU. It owns the program counter and drives the address of the combinational program ROM. It registers the returned instruction word, together with its PC, toward decode. It supports stall from downstream, redirect (branch/jump) from execute, and halts when it fetches an all-zero word, which the ROM returns for unprogrammed addresses.

---
 rtl/cpu_fetch_unit.sv | 86 ++++++++
 tb/tb_cpu_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational program ROM,
// registers instruction + PC toward decode, with stall, redirect and halt-on-zero.
module cpu_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 12,
    parameter int RESET_PC = 1
) (
    input  logic               Clock,
    input  logic               Reset_n,
    output logic [ADDR_W-1:0]  RomAddress,
    input  logic [INSTR_W-1:0] RomData,
    input  logic               Stall,
    input  logic               BranchValid,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               InstrValid,
    output logic               Halted,
    output logic [15:0]        FetchCount
);

    typedef enum logic {S_FETCH = 1'b0, S_HALTED = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);

    state_t               r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [INSTR_W-1:0]   r_instr;
    logic [ADDR_W-1:0]    r_instr_pc;
    logic                 r_valid;
    logic                 r_halted;
    logic [15:0]          r_count;
    logic                 w_zero_word;

    assign w_zero_word = (RomData == '0);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_FETCH;
            r_pc       <= LP_RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= '0;
        end else if (BranchValid) begin
            // Redirect wins over stall and halt; the presented word is flushed.
            r_pc     <= BranchTarget;
            r_valid  <= 1'b0;
            r_state  <= S_FETCH;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_HALTED: begin
                    r_valid <= 1'b0;
                end
                S_FETCH: begin
                    if (!Stall) begin
                        if (!w_zero_word) begin
                            r_instr    <= RomData;
                            r_instr_pc <= r_pc;
                            r_valid    <= 1'b1;
                            r_pc       <= r_pc + 1'b1;
                            if (r_count != 16'hFFFF)
                                r_count <= r_count + 16'd1;
                        end else begin
                            // PC parks on the zero address so it stays visible while halted.
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                            r_valid  <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign RomAddress = r_pc;
    assign Instr      = r_instr;
    assign InstrPC    = r_instr_pc;
    assign InstrValid = r_valid;
    assign Halted     = r_halted;
    assign FetchCount = r_count;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed scenarios from the fetch rules plus a
// randomized run checked against a cycle-level behavioural model.
module tb_cpu_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [7:0]  RomAddress;
    logic [11:0] RomData;
    logic        Stall;
    logic        BranchValid;
    logic [7:0]  BranchTarget;
    logic [11:0] Instr;
    logic [7:0]  InstrPC;
    logic        InstrValid;
    logic        Halted;
    logic [15:0] FetchCount;

    logic [11:0] rom [256];

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    logic [7:0]  m_pc;
    logic [11:0] m_instr;
    logic [7:0]  m_ipc;
    logic        m_valid;
    logic        m_halted;
    int          m_cnt;

    always #5 Clock = ~Clock;

    assign RomData = rom[RomAddress];

    cpu_fetch_unit #(.ADDR_W(8), .INSTR_W(12), .RESET_PC(1)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .RomAddress(RomAddress), .RomData(RomData),
        .Stall(Stall), .BranchValid(BranchValid), .BranchTarget(BranchTarget),
        .Instr(Instr), .InstrPC(InstrPC), .InstrValid(InstrValid),
        .Halted(Halted), .FetchCount(FetchCount)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 8'd1; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
    endtask

    // One clock edge of the fetch rules, evaluated with the inputs about to be sampled.
    task automatic model_edge();
        logic [11:0] word;
        word = rom[m_pc];
        if (BranchValid) begin
            m_pc = BranchTarget; m_valid = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (Stall) begin
            m_valid = m_valid;
        end else if (word != 12'd0) begin
            m_instr = word; m_ipc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 8'd1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_halted = 1'b1; m_valid = 1'b0;
        end
    endtask

    task automatic init_rom();
        for (int i = 0; i < 256; i++) begin
            rom[i] = ($urandom_range(0, 15) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
        end
        rom[0] = 12'd0;   rom[1] = 12'd289;  rom[2] = 12'd256;  rom[3] = 12'd278;
        rom[4] = 12'd513; rom[5] = 12'd77;   rom[26] = 12'd1635; rom[27] = 12'd3120;
        rom[45] = 12'd1655; rom[46] = 12'd3097; rom[47] = 12'd0; rom[255] = 12'd0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Stall = 1'b0; BranchValid = 1'b0; BranchTarget = '0;
        #12;
        n_tests++;
        if (RomAddress !== 8'd1 || Instr !== 12'd0 || InstrPC !== 8'd0 ||
            InstrValid !== 1'b0 || Halted !== 1'b0 || FetchCount !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: addr=%0d instr=%0d ipc=%0d v=%0b h=%0b cnt=%0d, want 1/0/0/0/0/0",
                     RomAddress, Instr, InstrPC, InstrValid, Halted, FetchCount);
        end
    endtask

    task automatic test_seq_fetch();
        logic [11:0] exp_i [3];
        exp_i[0] = 12'd289; exp_i[1] = 12'd256; exp_i[2] = 12'd278;
        @(negedge Clock);
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (Instr !== exp_i[k] || InstrPC !== 8'(k + 1) || InstrValid !== 1'b1 ||
                FetchCount !== 16'(k + 1)) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d]: got %0d/%0d v=%0b cnt=%0d, want %0d/%0d v=1 cnt=%0d",
                         k, Instr, InstrPC, InstrValid, FetchCount, exp_i[k], k + 1, k + 1);
            end
        end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (Instr !== 12'd278 || InstrPC !== 8'd3 || FetchCount !== 16'd3 ||
                InstrValid !== 1'b1 || RomAddress !== 8'd4) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %0d/%0d cnt=%0d v=%0b addr=%0d, want 278/3 cnt=3 v=1 addr=4",
                         k, Instr, InstrPC, FetchCount, InstrValid, RomAddress);
            end
        end
        Stall = 1'b0;
        tick();
        n_tests++;
        if (Instr !== 12'd513 || InstrPC !== 8'd4 || FetchCount !== 16'd4 || InstrValid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got %0d/%0d cnt=%0d v=%0b, want 513/4 cnt=4 v=1",
                     Instr, InstrPC, FetchCount, InstrValid);
        end
    endtask

    task automatic test_redirect();
        Stall = 1'b1; BranchValid = 1'b1; BranchTarget = 8'd26;
        tick();
        BranchValid = 1'b0; Stall = 1'b0;
        n_tests++;
        if (InstrValid !== 1'b0 || RomAddress !== 8'd26 || Instr !== 12'd513 || FetchCount !== 16'd4) begin
            n_fail++;
            $display("FAIL redirect_flush: v=%0b addr=%0d instr=%0d cnt=%0d, want v=0 addr=26 instr=513 cnt=4",
                     InstrValid, RomAddress, Instr, FetchCount);
        end
        tick();
        n_tests++;
        if (Instr !== 12'd1635 || InstrPC !== 8'd26 || InstrValid !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_first: got %0d/%0d v=%0b, want 1635/26 v=1", Instr, InstrPC, InstrValid);
        end
        tick();
        n_tests++;
        if (Instr !== 12'd3120 || InstrPC !== 8'd27 || FetchCount !== 16'd6) begin
            n_fail++;
            $display("FAIL redirect_second: got %0d/%0d cnt=%0d, want 3120/27 cnt=6", Instr, InstrPC, FetchCount);
        end
    endtask

    task automatic test_halt();
        BranchValid = 1'b1; BranchTarget = 8'd45;
        tick();
        BranchValid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (Instr !== 12'd3097 || InstrPC !== 8'd46 || RomAddress !== 8'd47) begin
            n_fail++;
            $display("FAIL halt_pre: got %0d/%0d addr=%0d, want 3097/46 addr=47", Instr, InstrPC, RomAddress);
        end
        // a zero word under stall must not halt
        Stall = 1'b1;
        tick(); tick();
        n_tests++;
        if (Halted !== 1'b0 || InstrValid !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_stalled_zero: h=%0b v=%0b, want h=0 v=1", Halted, InstrValid);
        end
        Stall = 1'b0;
        tick();
        n_tests++;
        if (Halted !== 1'b1 || InstrValid !== 1'b0 || RomAddress !== 8'd47 ||
            Instr !== 12'd3097 || InstrPC !== 8'd46 || FetchCount !== 16'd8) begin
            n_fail++;
            $display("FAIL halt_enter: h=%0b v=%0b addr=%0d %0d/%0d cnt=%0d, want h=1 v=0 addr=47 3097/46 cnt=8",
                     Halted, InstrValid, RomAddress, Instr, InstrPC, FetchCount);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (Halted !== 1'b1 || InstrValid !== 1'b0 || RomAddress !== 8'd47) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: h=%0b v=%0b addr=%0d, want h=1 v=0 addr=47",
                         k, Halted, InstrValid, RomAddress);
            end
        end
        BranchValid = 1'b1; BranchTarget = 8'd1;
        tick();
        BranchValid = 1'b0;
        n_tests++;
        if (Halted !== 1'b0 || RomAddress !== 8'd1 || InstrValid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exit: h=%0b addr=%0d v=%0b, want h=0 addr=1 v=0", Halted, RomAddress, InstrValid);
        end
        tick();
        n_tests++;
        if (Instr !== 12'd289 || InstrPC !== 8'd1 || InstrValid !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_resume: got %0d/%0d v=%0b, want 289/1 v=1", Instr, InstrPC, InstrValid);
        end
    endtask

    task automatic test_wrap();
        BranchValid = 1'b1; BranchTarget = 8'd255;
        tick();
        BranchValid = 1'b0;
        tick();
        n_tests++;
        if (Halted !== 1'b1 || InstrPC !== 8'd1 || Instr !== 12'd289 || RomAddress !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_zero: h=%0b %0d/%0d addr=%0d, want h=1 289/1 addr=255",
                     Halted, Instr, InstrPC, RomAddress);
        end
        rom[255] = 12'd999;
        BranchValid = 1'b1; BranchTarget = 8'd255;
        tick();
        BranchValid = 1'b0;
        tick();
        n_tests++;
        if (Instr !== 12'd999 || InstrPC !== 8'd255 || RomAddress !== 8'd0 || Halted !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_deliver: %0d/%0d addr=%0d h=%0b, want 999/255 addr=0 h=0",
                     Instr, InstrPC, RomAddress, Halted);
        end
        tick();
        n_tests++;
        if (Halted !== 1'b1 || RomAddress !== 8'd0 || InstrValid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_halt: h=%0b addr=%0d v=%0b, want h=1 addr=0 v=0", Halted, RomAddress, InstrValid);
        end
        rom[255] = 12'd0;
    endtask

    task automatic test_async_reset();
        BranchValid = 1'b1; BranchTarget = 8'd2;
        tick();
        BranchValid = 1'b0;
        tick(); tick();
        #2;
        Reset_n = 1'b0; Stall = 1'b1; BranchValid = 1'b1; BranchTarget = 8'd99;
        #1;
        n_tests++;
        if (RomAddress !== 8'd1 || Instr !== 12'd0 || InstrPC !== 8'd0 || InstrValid !== 1'b0 ||
            Halted !== 1'b0 || FetchCount !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: addr=%0d %0d/%0d v=%0b h=%0b cnt=%0d, want 1 0/0 v=0 h=0 cnt=0",
                     RomAddress, Instr, InstrPC, InstrValid, Halted, FetchCount);
        end
        @(negedge Clock);
        Stall = 1'b0; BranchValid = 1'b0; Reset_n = 1'b1;
        tick();
        n_tests++;
        if (Instr !== 12'd289 || InstrPC !== 8'd1 || FetchCount !== 16'd1 || InstrValid !== 1'b1) begin
            n_fail++;
            $display("FAIL async_release: %0d/%0d cnt=%0d v=%0b, want 289/1 cnt=1 v=1",
                     Instr, InstrPC, FetchCount, InstrValid);
        end
    endtask

    task automatic test_random();
        Reset_n = 1'b0; Stall = 1'b0; BranchValid = 1'b0;
        #3;
        model_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
        for (int k = 0; k < 400; k++) begin
            Stall        = ($urandom_range(0, 9) < 3);
            BranchValid  = ($urandom_range(0, 9) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            BranchTarget = 8'($urandom_range(0, 255));
            model_edge();
            tick();
            n_tests++;
            if (RomAddress !== m_pc || Instr !== m_instr || InstrPC !== m_ipc ||
                InstrValid !== m_valid || Halted !== m_halted || FetchCount !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL random[%0d]: addr=%0d %0d/%0d v=%0b h=%0b cnt=%0d, want addr=%0d %0d/%0d v=%0b h=%0b cnt=%0d",
                         k, RomAddress, Instr, InstrPC, InstrValid, Halted, FetchCount,
                         m_pc, m_instr, m_ipc, m_valid, m_halted, m_cnt);
            end
        end
        BranchValid = 1'b0; Stall = 1'b0;
    endtask

    initial begin
        init_rom();
        test_reset();
        test_seq_fetch();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
